// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bus of the shared register arbiter: request/write/data in,
// grant status and the shared register value out.
interface shared_reg_arbiter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       we;
  logic [N_REQ*WIDTH-1:0] d_bus;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic [2:0]             owner;
  logic [WIDTH-1:0]       q;
  logic [WIDTH-1:0]       q_bar;
  logic                   timeout;

  modport slave (
    input  req, we, d_bus,
    output gnt, busy, owner, q, q_bar, timeout
  );

  modport master (
    output req, we, d_bus,
    input  gnt, busy, owner, q, q_bar, timeout
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter owning one shared WIDTH-bit register with a hold-time limit.
// Optional SHARED_REG_PRESET_EN adds a preset input selecting the reset value of q.
module shared_reg_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned HOLD_MAX = 8
) (
  input logic clk,
  input logic rst,
`ifdef SHARED_REG_PRESET_EN
  input logic preset,
`endif
  shared_reg_arbiter_if.slave bus
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned HW = $clog2(HOLD_MAX);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [2:0]       owner_q, owner_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             timeout_q, timeout_d;
  logic [WIDTH-1:0] q_q, q_d;

  logic [IW-1:0]    own_idx;
  logic             own_req;
  logic [WIDTH-1:0] own_data;
  logic             found;
  logic [IW-1:0]    win;
  int unsigned      cand;

  assign own_idx  = owner_q[IW-1:0];
  assign own_req  = bus.req[own_idx];
  assign own_data = bus.d_bus[32'(own_idx)*WIDTH +: WIDTH];

  // Rotating-priority scan starting at ptr; first requester found wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = (32'(ptr_q) + i) % N_REQ;
      if (!found && bus.req[IW'(cand)]) begin
        found = 1'b1;
        win   = IW'(cand);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    q_d       = q_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          gnt_d[win] = 1'b1;
          owner_d    = 3'(win);
          hold_d     = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (own_req && bus.we[own_idx]) q_d = own_data;
        hold_d = hold_q + 1'b1;
        if (!own_req) begin
          gnt_d   = '0;
          state_d = RELEASE;
        end else if (hold_q == HW'(HOLD_MAX - 1)) begin
          gnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        gnt_d   = '0;
        ptr_d   = (own_idx == IW'(N_REQ - 1)) ? '0 : own_idx + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
`ifdef SHARED_REG_PRESET_EN
      q_q       <= preset ? '1 : '0;
`else
      q_q       <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
      q_q       <= q_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = |gnt_q;
  assign bus.owner   = owner_q;
  assign bus.q       = q_q;
  assign bus.q_bar   = ~q_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter (WIDTH=8, N_REQ=4, HOLD_MAX=8).
module tb_shared_reg_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
`ifdef SHARED_REG_PRESET_EN
  logic preset = 1'b0;
`endif

  always #5 clk = ~clk;

  shared_reg_arbiter_if #(.WIDTH(8), .N_REQ(4)) bus ();

  shared_reg_arbiter #(.WIDTH(8), .N_REQ(4), .HOLD_MAX(8)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef SHARED_REG_PRESET_EN
    .preset(preset),
`endif
    .bus   (bus)
  );

  typedef struct {
    string      nm;
    logic [3:0] gnt;
    logic [2:0] owner;
    logic [7:0] q;
    logic       timeout;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  // Monitor: compare every post-edge expectation on the following falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tests++;
      if (bus.gnt !== e.gnt || bus.busy !== (|e.gnt) || bus.owner !== e.owner ||
          bus.q !== e.q || bus.q_bar !== ~e.q || bus.timeout !== e.timeout) begin
        failed++;
        $display("FAIL %s: got gnt=%b busy=%b owner=%0d q=%h q_bar=%h timeout=%b, want gnt=%b busy=%b owner=%0d q=%h q_bar=%h timeout=%b",
                 e.nm, bus.gnt, bus.busy, bus.owner, bus.q, bus.q_bar, bus.timeout,
                 e.gnt, |e.gnt, e.owner, e.q, ~e.q, e.timeout);
      end
    end
  end

  task automatic cyc(input string nm, input logic r, input logic [3:0] rq,
                     input logic [3:0] w, input logic [31:0] d,
                     input logic [3:0] eg, input logic [2:0] eo,
                     input logic [7:0] eq, input logic et);
    exp_t e;
    @(negedge clk);
    #1;
    rst       = r;
    bus.req   = rq;
    bus.we    = w;
    bus.d_bus = d;
    @(posedge clk);
    #1;
    e.nm = nm; e.gnt = eg; e.owner = eo; e.q = eq; e.timeout = et;
    exp_q.push_back(e);
  endtask

  initial begin
    bus.req   = '0;
    bus.we    = '0;
    bus.d_bus = '0;

    // Reset and idle
    cyc("reset0", 1'b0, 4'b0000, 4'b0000, 32'h0, 4'b0000, 3'd0, 8'h00, 1'b0);
    cyc("reset1", 1'b0, 4'b0000, 4'b0000, 32'h0, 4'b0000, 3'd0, 8'h00, 1'b0);
    cyc("idle",   1'b1, 4'b0000, 4'b0000, 32'h0, 4'b0000, 3'd0, 8'h00, 1'b0);

    // Single writer, requester 1
    cyc("sw_grant",   1'b1, 4'b0010, 4'b0010, 32'h0000A500, 4'b0010, 3'd1, 8'h00, 1'b0);
    cyc("sw_write",   1'b1, 4'b0010, 4'b0010, 32'h0000A500, 4'b0010, 3'd1, 8'hA5, 1'b0);
    cyc("sw_drop",    1'b1, 4'b0000, 4'b0000, 32'h0,        4'b0000, 3'd1, 8'hA5, 1'b0);
    cyc("sw_release", 1'b1, 4'b0000, 4'b0000, 32'h0,        4'b0000, 3'd1, 8'hA5, 1'b0);

    // Round robin from a fresh reset: 0,1,2,3,0
    cyc("rr_reset", 1'b0, 4'b0000, 4'b0000, 32'h0, 4'b0000, 3'd0, 8'h00, 1'b0);
    cyc("rr_g0",  1'b1, 4'b1111, 4'b0000, 32'h0, 4'b0001, 3'd0, 8'h00, 1'b0);
    cyc("rr_r0",  1'b1, 4'b1110, 4'b0000, 32'h0, 4'b0000, 3'd0, 8'h00, 1'b0);
    cyc("rr_i0",  1'b1, 4'b1111, 4'b0000, 32'h0, 4'b0000, 3'd0, 8'h00, 1'b0);
    cyc("rr_g1",  1'b1, 4'b1111, 4'b0000, 32'h0, 4'b0010, 3'd1, 8'h00, 1'b0);
    cyc("rr_r1",  1'b1, 4'b1101, 4'b0000, 32'h0, 4'b0000, 3'd1, 8'h00, 1'b0);
    cyc("rr_i1",  1'b1, 4'b1111, 4'b0000, 32'h0, 4'b0000, 3'd1, 8'h00, 1'b0);
    cyc("rr_g2",  1'b1, 4'b1111, 4'b0000, 32'h0, 4'b0100, 3'd2, 8'h00, 1'b0);
    cyc("rr_r2",  1'b1, 4'b1011, 4'b0000, 32'h0, 4'b0000, 3'd2, 8'h00, 1'b0);
    cyc("rr_i2",  1'b1, 4'b1111, 4'b0000, 32'h0, 4'b0000, 3'd2, 8'h00, 1'b0);
    cyc("rr_g3",  1'b1, 4'b1111, 4'b0000, 32'h0, 4'b1000, 3'd3, 8'h00, 1'b0);
    cyc("rr_r3",  1'b1, 4'b0111, 4'b0000, 32'h0, 4'b0000, 3'd3, 8'h00, 1'b0);
    cyc("rr_i3",  1'b1, 4'b1111, 4'b0000, 32'h0, 4'b0000, 3'd3, 8'h00, 1'b0);
    cyc("rr_g0b", 1'b1, 4'b1111, 4'b0000, 32'h0, 4'b0001, 3'd0, 8'h00, 1'b0);
    cyc("rr_r0b", 1'b1, 4'b1110, 4'b0000, 32'h0, 4'b0000, 3'd0, 8'h00, 1'b0);
    cyc("rr_i0b", 1'b1, 4'b0000, 4'b0000, 32'h0, 4'b0000, 3'd0, 8'h00, 1'b0);
    cyc("rr_idle",1'b1, 4'b0000, 4'b0000, 32'h0, 4'b0000, 3'd0, 8'h00, 1'b0);

    // Timeout: requester 2 held, writing 0x30+k in hold cycle k
    cyc("to_grant", 1'b1, 4'b0100, 4'b0000, 32'h0, 4'b0100, 3'd2, 8'h00, 1'b0);
    for (int k = 0; k < 8; k++)
      cyc("to_hold", 1'b1, 4'b0100, 4'b0100, {8'h00, 8'h30 + 8'(k), 16'h0000},
          (k < 7) ? 4'b0100 : 4'b0000, 3'd2, 8'h30 + 8'(k), k == 7);
    cyc("to_release", 1'b1, 4'b0100, 4'b0000, 32'h0, 4'b0000, 3'd2, 8'h37, 1'b0);
    cyc("to_regrant", 1'b1, 4'b0100, 4'b0000, 32'h0, 4'b0100, 3'd2, 8'h37, 1'b0);
    cyc("to_hold2",   1'b1, 4'b0100, 4'b0000, 32'h0, 4'b0100, 3'd2, 8'h37, 1'b0);
    cyc("to_drop",    1'b1, 4'b0000, 4'b0000, 32'h0, 4'b0000, 3'd2, 8'h37, 1'b0);
    cyc("to_idle",    1'b1, 4'b0000, 4'b0000, 32'h0, 4'b0000, 3'd2, 8'h37, 1'b0);

    // Illegal writes: non-owner we, and owner we without req
    cyc("ill_grant0", 1'b1, 4'b0001, 4'b0000, 32'h0,        4'b0001, 3'd0, 8'h37, 1'b0);
    cyc("ill_nonown", 1'b1, 4'b0001, 4'b1110, 32'hFFFFFF00, 4'b0001, 3'd0, 8'h37, 1'b0);
    cyc("ill_noreq",  1'b1, 4'b0000, 4'b0001, 32'h000000AA, 4'b0000, 3'd0, 8'h37, 1'b0);
    cyc("ill_rel",    1'b1, 4'b0000, 4'b0000, 32'h0,        4'b0000, 3'd0, 8'h37, 1'b0);

    // Reset during a GRANT write cycle discards the write
    cyc("rg_grant", 1'b1, 4'b0010, 4'b0000, 32'h0,        4'b0010, 3'd1, 8'h37, 1'b0);
    cyc("rg_reset", 1'b0, 4'b0010, 4'b0010, 32'h0000CC00, 4'b0000, 3'd0, 8'h00, 1'b0);
    cyc("rg_idle",  1'b1, 4'b0000, 4'b0000, 32'h0,        4'b0000, 3'd0, 8'h00, 1'b0);

`ifdef SHARED_REG_PRESET_EN
    preset = 1'b1;
    cyc("preset1",  1'b0, 4'b0000, 4'b0000, 32'h0, 4'b0000, 3'd0, 8'hFF, 1'b0);
    cyc("preset1r", 1'b1, 4'b0000, 4'b0000, 32'h0, 4'b0000, 3'd0, 8'hFF, 1'b0);
    preset = 1'b0;
    cyc("preset0",  1'b0, 4'b0000, 4'b0000, 32'h0, 4'b0000, 3'd0, 8'h00, 1'b0);
`endif

    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(posedge clk);
    if (exp_q.size() > 0) begin
      failed++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
